// File: rtl/remrr_pkg.sv
// ============================================================================
// Module : remrr_pkg
// Brief  : Shared state encoding and default widths for the remrr arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package remrr_pkg;

    localparam int DW = 16;
    localparam int VW = 4;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/remrr_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int k;
        idx   = '0;
        grant = '0;
        any   = |req;
        k     = 0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (req[k]) begin
                idx = IW'(k);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/remrr_arbiter.sv
// ============================================================================
// Module : remrr_arbiter
// Brief  : Round-robin sharing of one remainder-by-msb1-divisor unit among
//          NREQ requesters. Optional divisor check: REMRR_DIVCHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module remrr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = remrr_pkg::DW,
    parameter int VW   = remrr_pkg::VW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_dividend,
    input  logic [NREQ*VW-1:0]   req_divisor,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [VW-1:0]        resp_rem,
    output logic                 resp_err,
    output logic                 du_start,
    output logic [DW-1:0]        du_dividend,
    output logic [VW-1:0]        du_divisor,
    input  logic [VW-1:0]        du_result,
    input  logic                 du_result_ready
);

    import remrr_pkg::*;

    localparam int            IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic            wait_armed;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [DW-1:0]   sel_dividend;
    logic [VW-1:0]   sel_divisor;
    logic            div_bad;
    logic            accept;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign sel_dividend = req_dividend[pick_idx*DW +: DW];
    assign sel_divisor  = req_divisor[pick_idx*VW +: VW];
    assign accept       = (state == ST_IDLE) && pick_any;

`ifdef REMRR_DIVCHECK_EN
    assign div_bad = ~sel_divisor[VW-1];
`else
    assign div_bad = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (state == ST_IDLE) ? pick_grant : '0;
    assign resp_valid = (state == ST_RESP) ? (NREQ'(1) << gidx) : '0;
    assign du_start   = (state == ST_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_SYNC:  if (du_result_ready) state_nx = ST_IDLE;
            ST_IDLE:  if (pick_any) state_nx = div_bad ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            // The unit's ready from before our start is stale on the first WAIT cycle.
            ST_WAIT:  if (wait_armed && du_result_ready) state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            gidx        <= '0;
            wait_armed  <= 1'b0;
            du_dividend <= '0;
            du_divisor  <= '0;
            resp_rem    <= '0;
`ifdef REMRR_DIVCHECK_EN
            resp_err    <= 1'b0;
`endif
        end else begin
            wait_armed <= (state == ST_WAIT);
            if (accept) begin
                du_dividend <= sel_dividend;
                du_divisor  <= sel_divisor;
                gidx        <= pick_idx;
                ptr         <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
`ifdef REMRR_DIVCHECK_EN
                resp_err    <= div_bad;
                if (div_bad) begin
                    resp_rem <= '0;
                end
`endif
            end
            if ((state == ST_WAIT) && wait_armed && du_result_ready) begin
                resp_rem <= du_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_remrr_arbiter.sv
// ============================================================================
// Module : tb_remrr_arbiter
// Brief  : Self-checking bench for remrr_arbiter with a behavioural divider unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_remrr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int VW   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [DW-1:0]       op_dvd [NREQ];
    logic [VW-1:0]       op_dvs [NREQ];
    logic [NREQ*DW-1:0]  req_dividend;
    logic [NREQ*VW-1:0]  req_divisor;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     resp_valid;
    logic [VW-1:0]       resp_rem;
    logic                resp_err;
    logic                du_start;
    logic [DW-1:0]       du_dividend;
    logic [VW-1:0]       du_divisor;
    logic [VW-1:0]       du_result;
    logic                du_result_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_dividend = '0;
        req_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*DW +: DW] = op_dvd[i];
            req_divisor[i*VW +: VW]  = op_dvs[i];
        end
    end

    remrr_arbiter #(.NREQ(NREQ), .DW(DW), .VW(VW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_rem        (resp_rem),
        .resp_err        (resp_err),
        .du_start        (du_start),
        .du_dividend     (du_dividend),
        .du_divisor      (du_divisor),
        .du_result       (du_result),
        .du_result_ready (du_result_ready)
    );

    // Divider unit model: no reset, busy for unit_lat cycles after start.
    int          cyc = 0;
    int          unit_lat = 1;
    int          force_until = 0;
    logic        um_busy = 1'b0;
    int          um_cnt = 0;
    logic [VW-1:0] um_res = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (du_start) begin
            um_busy <= 1'b1;
            um_cnt  <= unit_lat;
            um_res  <= (du_divisor == '0) ? '0 : VW'(du_dividend % DW'(du_divisor));
        end else if (um_busy) begin
            if (um_cnt <= 1) um_busy <= 1'b0;
            else             um_cnt  <= um_cnt - 1;
        end
    end

    assign du_result_ready = !um_busy && !du_start && (cyc >= force_until);
    assign du_result       = um_res;

    // Scoreboard: expectation pushed on acceptance, popped on response.
    typedef struct packed {
        logic [1:0]    idx;
        logic [VW-1:0] rem;
        logic          err;
    } exp_t;

    exp_t            sb [$];
    int              grant_log [$];
    int              n_start = 0;
    int              n_resp = 0;
    exp_t            e;
    logic [NREQ-1:0] oh_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (|req_ready) begin
                tests++;
                if (!$onehot(req_ready)) begin
                    fails++;
                    $display("FAIL req_ready_onehot: got %b, required one-hot", req_ready);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        e.idx = 2'(i);
                        e.rem = VW'(op_dvd[i] % DW'(op_dvs[i]));
                        e.err = 1'b0;
                        sb.push_back(e);
                        grant_log.push_back(i);
                    end
                end
            end
            if (du_start) n_start++;
            if (|resp_valid) begin
                n_resp++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL resp_unexpected: got resp_valid=%b, required none", resp_valid);
                end else begin
                    e = sb.pop_front();
                    oh_exp = '0;
                    oh_exp[e.idx] = 1'b1;
                    if (resp_valid !== oh_exp || resp_rem !== e.rem || resp_err !== e.err) begin
                        fails++;
                        $display("FAIL resp_data: got valid=%b rem=%0d err=%b, required valid=%b rem=%0d err=%b",
                                 resp_valid, resp_rem, resp_err, oh_exp, e.rem, e.err);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clock: note acceptances mid-cycle, drop those requests after the edge.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic drain(input int budget, input string name);
        int k = 0;
        while ((req_valid != '0 || sb.size() != 0) && k < budget) begin
            cycle();
            k++;
        end
        tests++;
        if (k >= budget) begin
            fails++;
            $display("FAIL %s_timeout: got %0d cycles pending, required completion", name, k);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int stalled = 0;
        int bad = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_dvd[i] = 16'd0;
            op_dvs[i] = 4'd8;
        end
        force_until = cyc + 10;
        rst_n = 1'b0;
        tick(2);
        tests++;
        if ({req_ready, resp_valid, du_start} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got ready=%b resp=%b start=%b, required zeros", req_ready, resp_valid, du_start);
        end
        tests++;
        if (resp_rem !== '0 || resp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_resp: got rem=%0d err=%b, required 0 0", resp_rem, resp_err);
        end
        tests++;
        if (du_dividend !== '0 || du_divisor !== '0) begin
            fails++;
            $display("FAIL reset_operands: got %0d %0d, required 0 0", du_dividend, du_divisor);
        end
        rst_n = 1'b1;
        op_dvd[0] = 16'd1000;
        op_dvs[0] = 4'd9;
        req_valid = 4'b0001;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (du_result_ready) break;
            stalled++;
            if (req_ready !== '0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL sync_hold: got %0d early grants, required 0", bad);
        end
        tests++;
        if (stalled < 7) begin
            fails++;
            $display("FAIL sync_stall: got %0d busy cycles, required >= 7", stalled);
        end
    endtask

    task automatic test_single();
        int t_acc = -1;
        int t_resp = -1;
        int s0 = n_start;
        logic [NREQ-1:0] acc;
        for (int k = 0; k < 40 && t_resp < 0; k++) begin
            @(negedge clk);
            acc = req_ready;
            if (req_ready[0]) t_acc = cyc;
            if (resp_valid[0]) t_resp = cyc;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        tests++;
        if (t_acc < 0 || t_resp < 0 || (t_resp - t_acc) != 3 + unit_lat) begin
            fails++;
            $display("FAIL single_latency: got acc=%0d resp=%0d, required gap %0d", t_acc, t_resp, 3 + unit_lat);
        end
        tests++;
        if (n_start - s0 != 1) begin
            fails++;
            $display("FAIL single_start: got %0d start pulses, required 1", n_start - s0);
        end
        tests++;
        if (du_dividend !== 16'd1000 || du_divisor !== 4'd9) begin
            fails++;
            $display("FAIL single_operands: got %0d %0d, required 1000 9", du_dividend, du_divisor);
        end
    endtask

    task automatic test_all_four();
        unit_lat = 3;
        do_reset();
        op_dvd[0] = 16'd1000;  op_dvs[0] = 4'd13;
        op_dvd[1] = 16'd50000; op_dvs[1] = 4'd11;
        op_dvd[2] = 16'd65535; op_dvs[2] = 4'd15;
        op_dvd[3] = 16'd7;     op_dvs[3] = 4'd12;
        grant_log.delete();
        req_valid = 4'b1111;
        drain(200, "all_four");
        tests++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 ||
            grant_log[2] != 2 || grant_log[3] != 3) begin
            fails++;
            $display("FAIL all_four_order: got %p, required 0 1 2 3", grant_log);
        end
        grant_log.delete();
        req_valid = 4'b1010;
        drain(100, "ptr_wrap");
        tests++;
        if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 3) begin
            fails++;
            $display("FAIL ptr_wrap_order: got %p, required 1 3", grant_log);
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        unit_lat = 2;
        grant_log.delete();
        req_valid = 4'b0100;
        for (int k = 0; k < 20 && grant_log.size() == 0; k++) cycle();
        req_valid[1] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid[2]) begin
                req_valid[2] = 1'b1;
                seen = 1'b1;
                break;
            end
        end
        drain(100, "b2b");
        tests++;
        if (!seen || grant_log.size() != 3 || grant_log[0] != 2 || grant_log[1] != 1 || grant_log[2] != 2) begin
            fails++;
            $display("FAIL b2b_order: got %p (resp seen %0d), required 2 1 2", grant_log, seen);
        end
    endtask

    task automatic test_reset_mid();
        int s0 = n_start;
        int r0;
        int bad = 0;
        int stalled = 0;
        unit_lat = 8;
        op_dvd[0] = 16'd40000; op_dvs[0] = 4'd14;
        op_dvd[1] = 16'd12345; op_dvs[1] = 4'd10;
        req_valid = 4'b0001;
        for (int k = 0; k < 20 && n_start == s0; k++) cycle();
        tick(2);
        rst_n = 1'b0;
        sb.delete();
        tick(1);
        tests++;
        if (resp_valid !== '0 || req_ready !== '0 || du_start !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got resp=%b ready=%b start=%b, required zeros", resp_valid, req_ready, du_start);
        end
        rst_n = 1'b1;
        r0 = n_resp;
        grant_log.delete();
        req_valid = 4'b0010;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (du_result_ready) break;
            stalled++;
            if (req_ready !== '0 || resp_valid !== '0) bad++;
        end
        tests++;
        if (bad != 0 || stalled < 2) begin
            fails++;
            $display("FAIL mid_reset_sync: got %0d bad cycles, %0d stalled, required 0 and >= 2", bad, stalled);
        end
        drain(100, "after_reset");
        tests++;
        if (n_resp - r0 != 1 || grant_log.size() != 1 || grant_log[0] != 1) begin
            fails++;
            $display("FAIL after_reset_serve: got %0d resps grants %p, required 1 resp grant 1", n_resp - r0, grant_log);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_reset_mid();
        tick(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
